// File: rtl/mtm_alu_ctrl.sv
// Sequencer between the deserializer, the shared ALU core and the serializer.
// Captures one command or error frame, runs the ALU under a timeout and streams the response bytes.
module mtm_alu_ctrl #(
    parameter int unsigned TIMEOUT_CYC   = 16,
    parameter logic [7:0]  TIMEOUT_FRAME = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    input  logic [2:0]  cmd_op_i,
    input  logic        err_valid_i,
    input  logic [7:0]  err_frame_i,
    output logic        alu_start_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [2:0]  alu_op_o,
    input  logic        alu_done_i,
    input  logic [31:0] alu_result_i,
    input  logic [3:0]  alu_flags_i,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_is_ctl_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic [7:0]  drop_cnt_o
);

    typedef enum logic [2:0] {
        StIdle, StAluReq, StAluWait, StSendData, StSendCtl, StSendErr, StSendTo
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, b_q, result_q;
    logic [2:0]  op_q, crc_q;
    logic [7:0]  err_q, drop_q, drop_d;
    logic [3:0]  flags_q;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] wait_q, wait_d;
    logic        tx_valid_q, tx_valid_d;
    logic        cmd_load, err_load, res_load, tx_fire;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;

    // Galois LFSR for x^3+x+1, bits fed MSB first.
    function automatic logic [2:0] crc3(input logic [35:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 35; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign tx_fire = tx_valid_q && tx_ready_i;

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        wait_d     = wait_q;
        cmd_load   = 1'b0;
        err_load   = 1'b0;
        res_load   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (err_valid_i) begin
                    err_load = 1'b1;
                    state_d  = StSendErr;
                end else if (cmd_valid_i) begin
                    cmd_load = 1'b1;
                    state_d  = StAluReq;
                end
            end
            StAluReq: begin
                wait_d  = '0;
                state_d = StAluWait;
            end
            StAluWait: begin
                if (alu_done_i) begin
                    res_load   = 1'b1;
                    byte_idx_d = 2'd0;
                    state_d    = StSendData;
                end else if (wait_q == 16'(TIMEOUT_CYC - 1)) begin
                    state_d = StSendTo;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            StSendData: begin
                if (tx_fire) begin
                    if (byte_idx_q == 2'd3) state_d = StSendCtl;
                    else byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            StSendCtl, StSendErr, StSendTo: begin
                if (tx_fire) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        tx_valid_d = (state_d == StSendData) || (state_d == StSendCtl) ||
                     (state_d == StSendErr)  || (state_d == StSendTo);
    end

    // Both pulses count while busy; in IDLE only a cmd losing to err is a drop.
    always_comb begin
        drop_inc = 2'd0;
        if (state_q != StIdle) drop_inc = {1'b0, cmd_valid_i} + {1'b0, err_valid_i};
        else if (cmd_valid_i && err_valid_i) drop_inc = 2'd1;
        drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            err_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            crc_q      <= '0;
            byte_idx_q <= '0;
            wait_q     <= '0;
            tx_valid_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            wait_q     <= wait_d;
            tx_valid_q <= tx_valid_d;
            drop_q     <= drop_d;
            if (cmd_load) begin
                a_q  <= cmd_a_i;
                b_q  <= cmd_b_i;
                op_q <= cmd_op_i;
            end
            if (err_load) err_q <= err_frame_i;
            if (res_load) begin
                result_q <= alu_result_i;
                flags_q  <= alu_flags_i;
                crc_q    <= crc3({alu_result_i, alu_flags_i});
            end
        end
    end

    always_comb begin
        tx_data_o   = 8'h00;
        tx_is_ctl_o = 1'b0;
        case (state_q)
            StSendData: begin
                unique case (byte_idx_q)
                    2'd0: tx_data_o = result_q[31:24];
                    2'd1: tx_data_o = result_q[23:16];
                    2'd2: tx_data_o = result_q[15:8];
                    2'd3: tx_data_o = result_q[7:0];
                endcase
            end
            StSendCtl: begin
                tx_data_o   = {1'b0, flags_q, crc_q};
                tx_is_ctl_o = 1'b1;
            end
            StSendErr: begin
                tx_data_o   = err_q;
                tx_is_ctl_o = 1'b1;
            end
            StSendTo: begin
                tx_data_o   = TIMEOUT_FRAME;
                tx_is_ctl_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_start_o = (state_q == StAluReq);
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;
    assign tx_valid_o  = tx_valid_q;
    assign busy_o      = (state_q != StIdle);
    assign drop_cnt_o  = drop_q;

endmodule
